mux8_rr_sequencer: RTL and testbench

- Upstream controller and downstream capture stage wrapped around an 8:1 word mux.
- Arbitrates 8 requesting channels round-robin and drives the mux 3-bit select.
- Registers the mux output and presents it on a valid/ready output handshake.
- Returns a one-cycle ack to the served channel; the mux itself stays external and combinational.

---
 rtl/mux8_rr_sequencer.sv | 137 +++++++++++++
 tb/tb_mux8_rr_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sequencer.sv
// Round-robin sequencer around an external 8:1 word mux: arbitrates req, drives sel,
// captures mux_data and presents it on a valid/ready port. MUX8_SEQ_FIXED_PRIO_EN selects fixed priority.
module mux8_rr_sequencer #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      req,
  output logic [2:0]      sel,
  input  logic [BITS-1:0] mux_data,
  output logic [7:0]      ack,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [1:0]      state_r, state_nxt_s;
  logic [2:0]      sel_r, sel_nxt_s;
  logic [7:0]      ack_r, ack_nxt_s;
  logic            out_valid_r, valid_nxt_s;
  logic [BITS-1:0] out_data_r, data_nxt_s;
  logic            busy_r;
  logic [2:0]      arb_start_s;
  logic [3:0]      win_s;

  // {found, index} of the first set request scanning start, start+1, ... modulo 8.
  // Scanning downward lets the lowest offset overwrite the others.
  function automatic logic [3:0] pick_winner(input logic [7:0] req_v, input logic [2:0] start);
    logic [3:0] result;
    logic [2:0] idx;
    result = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (req_v[idx]) begin
        result = {1'b1, idx};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

`ifdef MUX8_SEQ_FIXED_PRIO_EN
  assign arb_start_s = 3'd0;
`else
  logic [2:0] ptr_r;

  // Round-robin pointer advances past the channel being captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 3'd0;
    end else if (state_r == SETTLE) begin
      ptr_r <= sel_r + 3'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign arb_start_s = ptr_r;
`endif

  assign win_s = pick_winner(req, arb_start_s);

  // Next-state and next-output decode for the IDLE/SETTLE/HOLD sequence.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    ack_nxt_s   = 8'd0;
    valid_nxt_s = out_valid_r;
    data_nxt_s  = out_data_r;
    case (state_r)
      IDLE: begin
        if (win_s[3]) begin
          sel_nxt_s   = win_s[2:0];
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        // req is not re-checked here: the selected word is captured regardless.
        data_nxt_s  = mux_data;
        valid_nxt_s = 1'b1;
        ack_nxt_s   = 8'd1 << sel_r;
        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (out_valid_r && out_ready) begin
          valid_nxt_s = 1'b0;
          if (win_s[3]) begin
            sel_nxt_s   = win_s[2:0];
            state_nxt_s = SETTLE;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sel_r       <= 3'd0;
      ack_r       <= 8'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sel_r       <= sel_nxt_s;
      ack_r       <= ack_nxt_s;
      out_valid_r <= valid_nxt_s;
      out_data_r  <= data_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign sel       = sel_r;
  assign ack       = ack_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mux8_rr_sequencer.sv
// Self-checking bench for mux8_rr_sequencer: directed steps then randomized traffic,
// compared each cycle against a transaction-level reference model.
module tb_mux8_rr_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] mux_data;
  logic [7:0] ack;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic [7:0] ch_word [8];

  int vectors = 0;
  int miscompares = 0;

  // reference model: phase 0 = idle, 1 = word selected, 2 = word presented
  int         m_phase;
  logic [2:0] m_sel, m_ptr;
  logic [7:0] m_ack, m_data;
  logic       m_valid;

  mux8_rr_sequencer #(.BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .mux_data(mux_data),
    .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  // the external combinational mux
  assign mux_data = ch_word[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] w;
    bit found;
    int base;
    w = 3'd0;
    found = 0;
`ifdef MUX8_SEQ_FIXED_PRIO_EN
    base = 0 * int'(p);
`else
    base = int'(p);
`endif
    for (int i = 0; i < 8; i++) begin
      if (!found && r[(base + i) % 8]) begin
        w = 3'((base + i) % 8);
        found = 1;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sel = 3'd0; m_ptr = 3'd0;
    m_ack = 8'd0; m_data = 8'd0; m_valid = 1'b0;
  endtask

  task automatic compare_all();
    check("sel", 32'(sel), 32'(m_sel));
    check("ack", 32'(ack), 32'(m_ack));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("busy", 32'(busy), 32'(m_phase != 0));
  endtask

  // advance model and DUT one clock using the inputs currently driven
  task automatic tick();
    int         n_phase;
    logic [2:0] n_sel, n_ptr;
    logic [7:0] n_ack, n_data;
    logic       n_valid;
    n_phase = m_phase; n_sel = m_sel; n_ptr = m_ptr;
    n_ack = 8'd0; n_data = m_data; n_valid = m_valid;
    if (m_phase == 0) begin
      if (req != 8'd0) begin n_sel = pick(req, m_ptr); n_phase = 1; end
    end else if (m_phase == 1) begin
      n_data = ch_word[m_sel]; n_valid = 1'b1;
      n_ack = 8'(1 << m_sel); n_ptr = 3'((m_sel + 1) % 8); n_phase = 2;
    end else if (out_ready) begin
      n_valid = 1'b0;
      if (req != 8'd0) begin n_sel = pick(req, m_ptr); n_phase = 1; end
      else n_phase = 0;
    end
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      m_phase = n_phase; m_sel = n_sel; m_ptr = n_ptr;
      m_ack = n_ack; m_data = n_data; m_valid = n_valid;
    end
    compare_all();
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req = 8'd0; out_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    logic [2:0] rr_exp [4];
    int ack_cnt [8];
    int last_ack, cyc;

    rst_n = 1'b0; req = 8'hFF; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) ch_word[k] = 8'd0;
    model_reset();
    #12;
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();
    check("first_grant", 32'(sel), 32'd0);
    drain();

    // single request, dropped during the settle cycle but still captured
    req = 8'b0010_0000; ch_word[5] = 8'hA5; out_ready = 1'b0;
    tick();
    check("single_sel", 32'(sel), 32'd5);
    req = 8'd0;
    tick();
    check("single_data", 32'(out_data), 32'hA5);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_ack", 32'(ack), 32'h20);
    out_ready = 1'b1;
    tick();
    check("single_ack_pulse", 32'(ack), 32'd0);

    // round-robin wrap from pointer 0
    mid_reset();
`ifdef MUX8_SEQ_FIXED_PRIO_EN
    rr_exp = '{3'd0, 3'd0, 3'd0, 3'd0};
`else
    rr_exp = '{3'd0, 3'd7, 3'd0, 3'd7};
`endif
    req = 8'b1000_0001; out_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      if (j % 2 == 0) check("rr_wrap_sel", 32'(sel), 32'(rr_exp[j / 2]));
    end
    drain();

    // backpressure: word held while out_ready is low, new req waits
    req = 8'h08; ch_word[3] = 8'h3C; out_ready = 1'b0;
    tick();
    req = 8'd0;
    tick();
    req = 8'h40;
    repeat (5) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h3C);
      check("bp_sel", 32'(sel), 32'd3);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_sel", 32'(sel), 32'd6);
    drain();

    // async reset in the middle of the settle cycle
    req = 8'h02; out_ready = 1'b1;
    tick();
    check("settle_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sel", 32'(sel), 32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    tick();
    check("async_no_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    req = 8'd0;
    tick();

    // full load: 16 words, one every 2 cycles
    req = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) ack_cnt[k] = 0;
    last_ack = -1;
    for (cyc = 0; cyc < 33; cyc++) begin
      tick();
      if (ack != 8'd0) begin
        if (last_ack >= 0) check("full_gap", 32'(cyc - last_ack), 32'd2);
        last_ack = cyc;
      end
      for (int k = 0; k < 8; k++) if (ack[k]) ack_cnt[k]++;
    end
    for (int k = 0; k < 8; k++) begin
`ifdef MUX8_SEQ_FIXED_PRIO_EN
      check("full_ack_count", 32'(ack_cnt[k]), (k == 0) ? 32'd16 : 32'd0);
`else
      check("full_ack_count", 32'(ack_cnt[k]), 32'd2);
`endif
    end
    drain();

    // randomized traffic against the model
    repeat (400) begin
      req = 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ch_word[$urandom_range(0, 7)] = 8'($urandom);
      if ($urandom_range(0, 59) == 0) mid_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
